// File: rtl/seq_producer.sv
// seq_producer: arithmetic-sequence burst generator with valid/ready output
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   start, stop                 begin a burst (IDLE only) / end auto-repeat
//   start_val, step, count      burst setup, latched when start is accepted
//   dout, dout_valid, dout_ready  item stream with consumer backpressure
//   busy, done, sent            in RUN / one-cycle burst-end pulse / items accepted
//   dout_par                    even parity of dout, only with SEQ_PRODUCER_PARITY_EN
module seq_producer #(
    parameter int WIDTH  = 32,
    parameter int CW     = 8,
    parameter int REPEAT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] start_val,
    input  logic [WIDTH-1:0] step,
    input  logic [CW-1:0]    count,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    sent
`ifdef SEQ_PRODUCER_PARITY_EN
    ,
    output logic             dout_par
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] base_q, step_q, dout_n;
    logic [CW-1:0] count_q, sent_n, sent_inc;
    logic stop_q, stop_n, load;
    assign dout_valid = state == RUN;
    assign busy       = state == RUN;
    assign done       = state == DONE;
    always_comb begin
        state_n  = state;
        dout_n   = dout;
        sent_n   = sent;
        stop_n   = stop_q;
        load     = 1'b0;
        sent_inc = sent + CW'(1);
        case (state)
            IDLE: if (start) begin
                load    = 1'b1;
                stop_n  = 1'b0;
                sent_n  = '0;
                dout_n  = start_val;
                state_n = count == '0 ? DONE : RUN;
            end
            RUN: begin
                stop_n = stop_q | stop;
                if (dout_ready) begin
                    dout_n  = dout + step_q;
                    sent_n  = sent_inc;
                    state_n = sent_inc == count_q ? DONE : RUN;
                end
            end
            DONE: begin
                stop_n = stop_q | stop;
                // a zero-length burst never restarts, otherwise it would loop through DONE forever
                if (REPEAT != 0 && !(stop_q | stop) && count_q != '0) begin
                    state_n = RUN;
                    dout_n  = base_q;
                    sent_n  = '0;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            dout    <= '0;
            sent    <= '0;
            stop_q  <= 1'b0;
            base_q  <= '0;
            step_q  <= '0;
            count_q <= '0;
        end else begin
            state  <= state_n;
            dout   <= dout_n;
            sent   <= sent_n;
            stop_q <= stop_n;
            if (load) begin
                base_q  <= start_val;
                step_q  <= step;
                count_q <= count;
            end
        end
    end
`ifdef SEQ_PRODUCER_PARITY_EN
    always_ff @(posedge clk) dout_par <= rst_n ? ^dout_n : 1'b0;
`endif
endmodule

// File: tb/tb_seq_producer.sv
// tb_seq_producer: randomized scoreboard bench for seq_producer (single-shot and repeat builds)
module tb_seq_producer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_start, a_stop, a_ready, a_valid, a_busy, a_done;
    logic [31:0] a_start_val, a_step, a_dout;
    logic [7:0]  a_count, a_sent;
    logic        b_start, b_stop, b_ready, b_valid, b_busy, b_done;
    logic [7:0]  b_start_val, b_step, b_dout;
    logic [7:0]  b_count, b_sent;
`ifdef SEQ_PRODUCER_PARITY_EN
    logic        a_par, b_par;
`endif
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    seq_producer #(.WIDTH(32), .CW(8), .REPEAT(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .stop(a_stop),
        .start_val(a_start_val), .step(a_step), .count(a_count),
        .dout(a_dout), .dout_valid(a_valid), .dout_ready(a_ready),
        .busy(a_busy), .done(a_done), .sent(a_sent)
`ifdef SEQ_PRODUCER_PARITY_EN
        , .dout_par(a_par)
`endif
    );

    seq_producer #(.WIDTH(8), .CW(8), .REPEAT(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .stop(b_stop),
        .start_val(b_start_val), .step(b_step), .count(b_count),
        .dout(b_dout), .dout_valid(b_valid), .dout_ready(b_ready),
        .busy(b_busy), .done(b_done), .sent(b_sent)
`ifdef SEQ_PRODUCER_PARITY_EN
        , .dout_par(b_par)
`endif
    );

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected item k of a burst is start + k*step, truncated to the data width.
    // mode 0: always ready, 1: random ready, 2: ready low for 3 cycles while item 1 is offered
    task automatic burst_a(input logic [31:0] sv, input logic [31:0] st, input logic [7:0] cnt, input int mode);
        int k = 0, stall = 0, cyc;
        logic [31:0] exp;
        a_start = 1'b1; a_start_val = sv; a_step = st; a_count = cnt; a_ready = 1'b1;
        cycle();
        a_start = 1'b0;
        for (cyc = 0; cyc < 400; cyc++) begin
            a_start_val = $urandom;
            a_step      = $urandom;
            a_count     = 8'($urandom);
            a_start     = $urandom_range(0, 3) == 0;
            a_stop      = 1'($urandom_range(0, 1));
            a_ready     = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) : !(k == 1 && stall < 3);
            if (a_done) break;
            exp = sv + 32'(k) * st;
            check("a_valid", a_valid, 1);
            check("a_busy", a_busy, 1);
            check("a_dout", a_dout, exp);
            check("a_sent", a_sent, 64'(k));
`ifdef SEQ_PRODUCER_PARITY_EN
            check("a_par", a_par, ^exp);
`endif
            if (!a_ready) stall++;
            if (a_ready) k++;
            cycle();
        end
        if (cyc == 400) check("a_timeout", 1, 0);
        check("a_items", 64'(k), cnt);
        check("a_valid_in_done", a_valid, 0);
        check("a_sent_done", a_sent, cnt);
        a_start = 1'b0; a_stop = 1'b0;
        cycle();
        check("a_done_once", a_done, 0);
        check("a_busy_idle", a_busy, 0);
        cycle();
        check("a_sent_hold", a_sent, cnt);
        check("a_valid_idle", a_valid, 0);
    endtask

    // Repeat build: stop is pulsed on the first RUN cycle of burst nb-1, so exactly nb bursts occur.
    task automatic burst_b(input logic [7:0] sv, input logic [7:0] st, input logic [7:0] cnt, input int nb);
        int k = 0, b = 0, cyc;
        logic [7:0] exp;
        b_start = 1'b1; b_start_val = sv; b_step = st; b_count = cnt; b_ready = 1'b1; b_stop = 1'b0;
        cycle();
        b_start = 1'b0;
        for (cyc = 0; cyc < 600; cyc++) begin
            b_start_val = 8'($urandom);
            b_step      = 8'($urandom);
            b_count     = 8'($urandom);
            b_ready     = 1'($urandom_range(0, 1));
            b_stop      = 1'b0;
            if (b_done) begin
                check("b_items", 64'(k), cnt);
                check("b_valid_in_done", b_valid, 0);
                b++;
                k = 0;
                if (b == nb) break;
            end else begin
                exp = sv + 8'(k) * st;
                b_stop = b == nb - 1 && k == 0;
                check("b_valid", b_valid, 1);
                check("b_dout", b_dout, exp);
                check("b_sent", b_sent, 64'(k));
`ifdef SEQ_PRODUCER_PARITY_EN
                check("b_par", b_par, ^exp);
`endif
                if (b_ready) k++;
            end
            cycle();
        end
        if (cyc == 600) check("b_timeout", 1, 0);
        b_stop = 1'b0;
        cycle();
        check("b_stopped_busy", b_busy, 0);
        check("b_stopped_done", b_done, 0);
        repeat (3) cycle();
        check("b_no_restart", b_valid, 0);
        check("b_sent_hold", b_sent, cnt);
    endtask

    initial begin
        rst_n = 1'b0;
        a_start = 1'b0; a_stop = 1'b0; a_ready = 1'b1; a_start_val = '0; a_step = '0; a_count = '0;
        b_start = 1'b0; b_stop = 1'b0; b_ready = 1'b1; b_start_val = '0; b_step = '0; b_count = '0;
        cycle();
        cycle();
        check("rst_dout", a_dout, 0);
        check("rst_valid", a_valid, 0);
        check("rst_busy", a_busy, 0);
        check("rst_done", a_done, 0);
        check("rst_sent", a_sent, 0);
        check("rst_b_valid", b_valid, 0);
`ifdef SEQ_PRODUCER_PARITY_EN
        check("rst_par", a_par, 0);
`endif
        rst_n = 1'b1;
        cycle();
        burst_a(32'd0, 32'd1, 8'd6, 0);
        burst_a(32'd0, 32'd2, 8'd3, 2);
        burst_a(32'hFFFF_FFF0, 32'h8, 8'd5, 1);
        repeat (3) burst_a($urandom, $urandom, 8'($urandom_range(1, 20)), 1);
        burst_a($urandom, $urandom, 8'd0, 0);
        a_start = 1'b1; a_start_val = 32'd10; a_step = 32'd3; a_count = 8'd5; a_ready = 1'b1;
        cycle();
        a_start = 1'b0;
        cycle();
        cycle();
        check("mid_sent", a_sent, 2);
        check("mid_dout", a_dout, 16);
        rst_n = 1'b0;
        cycle();
        check("mrst_dout", a_dout, 0);
        check("mrst_valid", a_valid, 0);
        check("mrst_busy", a_busy, 0);
        check("mrst_done", a_done, 0);
        check("mrst_sent", a_sent, 0);
        rst_n = 1'b1;
        cycle();
        cycle();
        check("mrst_no_resume", a_valid, 0);
        burst_a(32'd10, 32'd3, 8'd5, 0);
        burst_b(8'hFE, 8'd1, 8'd4, 1);
        burst_b(8'd0, 8'd1, 8'd2, 3);
        burst_b(8'($urandom), 8'($urandom), 8'($urandom_range(1, 6)), 2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/seq_producer.md
SEQ_PRODUCER -- requirements
Module: seq_producer

Interface
REQ-001 Parameter WIDTH, default 32: data word width in bits (1..64).
REQ-002 Parameter CW, default 8: width of the item-count input and the sent counter.
REQ-003 Parameter REPEAT, default 0: 0 sends a single burst; 1 restarts the burst automatically until stop is seen.
REQ-004 Port clk, input, 1: sole clock; all logic is on the rising edge.
REQ-005 Port rst_n, input, 1: synchronous, active-low reset.
REQ-006 Port start, input, 1: one-cycle request to begin a burst; sampled only in IDLE.
REQ-007 Port stop, input, 1: REPEAT=1 only; ends repetition after the current burst completes.
REQ-008 Port start_val, input, WIDTH: first data value; latched when start is accepted.
REQ-009 Port step, input, WIDTH: increment added per accepted item; latched with start_val.
REQ-010 Port count, input, CW: number of items per burst; latched with start_val.
REQ-011 Port dout, output, WIDTH: current data item.
REQ-012 Port dout_valid, output, 1: dout holds a valid item.
REQ-013 Port dout_ready, input, 1: the consumer accepts the item this cycle.
REQ-014 Port busy, output, 1: high in RUN.
REQ-015 Port done, output, 1: one-cycle pulse when a burst completes.
REQ-016 Port sent, output, CW: items accepted in the current or last burst.

Function
REQ-017 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-018 IDLE -> RUN SHALL occur on start=1 with count!=0; start_val, step and count latch on the same edge.
REQ-019 start=1 with count=0 SHALL go IDLE -> DONE directly, with no dout_valid and sent cleared to 0.
REQ-020 In RUN, dout_valid=1 SHALL be asserted from the cycle after start is accepted; the first dout equals start_val.
REQ-021 A transfer SHALL occur on any rising edge with dout_valid=1 and dout_ready=1.
REQ-022 On each transfer, dout SHALL become dout+step (mod 2^WIDTH, wrapping silently) and sent SHALL increment.
REQ-023 While dout_valid=1 and dout_ready=0, dout SHALL be held stable and dout_valid SHALL stay high.
REQ-024 Back-to-back transfers SHALL sustain one item per cycle with no bubbles.
REQ-025 On the transfer that makes sent equal the latched count, the FSM SHALL enter DONE; dout_valid is 0 the next cycle.
REQ-026 DONE SHALL last exactly one cycle with done=1, then go to IDLE.
REQ-027 With REPEAT=1 and stop not seen since start, DONE SHALL instead go to RUN, reload dout=start_val and clear sent.
REQ-028 stop SHALL be latched whenever asserted in RUN or DONE; the latch clears on start acceptance.
REQ-029 start asserted in RUN or DONE SHALL be ignored.
REQ-030 sent SHALL hold its final value in IDLE until the next accepted start.
REQ-031 Changes to start_val, step or count during RUN SHALL have no effect on the burst in progress.

Reset
REQ-032 While rst_n=0 at a clock edge, the following SHALL apply: state=IDLE, dout=0, dout_valid=0, busy=0, done=0, sent=0, stop latch cleared.
REQ-033 Reset SHALL take priority over all inputs, including mid-burst; the partial burst is abandoned and does not resume.

Configuration
REQ-034 With SEQ_PRODUCER_PARITY_EN defined, output port dout_par (1 bit) SHALL equal the even parity (XOR) of dout, registered alongside dout, with reset value 0.
REQ-035 Without SEQ_PRODUCER_PARITY_EN, the dout_par port and its logic SHALL be absent.

Verification
REQ-036 Basic burst: WIDTH=32, start_val=0, step=1, count=6, dout_ready=1 -> dout 0,1,2,3,4,5 on consecutive cycles; done pulses once; sent=6.
REQ-037 Backpressure: count=3, step=2, dout_ready low for 3 cycles at item 1 -> dout holds 2 stable while stalled; sequence 0,2,4; sent=3.
REQ-038 Wrap-around: WIDTH=8, start_val=8'hFE, step=1, count=4 -> dout FE, FF, 00, 01.
REQ-039 Zero count: start with count=0 -> dout_valid stays 0; done=1 one cycle after start; sent=0.
REQ-040 Repeat: REPEAT=1, count=2, stop pulsed during the 3rd burst -> exactly 3 bursts of 0,1; done pulses 3 times.
REQ-041 Reset mid-burst: rst_n=0 after 2 of 5 transfers -> all outputs at reset values next cycle; a new start begins again at start_val.
